// File: rtl/vec_morph.sv
// vec_morph: progressively morphs a registered output vector toward a target
// vector by copying one pseudo-randomly chosen element per step.
//
// A 16-bit Galois LFSR (mask 16'hB400) runs every clock. Its top IDX_W bits
// select the element copied on each step. Steps happen every rate+1 cycles
// while a run is active.
//
// Compile-time option VEC_MORPH_COVER_EN:
//   defined   - a run ends on the step that has copied every index at least
//               once (STEPS is ignored).
//   undefined - a run ends on the STEPS-th step (STEPS=0 behaves as 1).
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle pulse, begins a run (ignored while running)
//   abort      - one-cycle pulse, ends a run without done
//   rate       - step interval minus one, sampled at start and at each reload
//   in         - target vector, element k at [k*ELEM_W +: ELEM_W]
//   out        - morphed vector (registered)
//   busy       - high while running
//   done       - one-cycle pulse with the final step_valid
//   step_valid - one-cycle pulse per step taken
//   step_idx   - index copied by the step flagged by step_valid
module vec_morph #(
  parameter int unsigned ELEMS  = 32,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned STEPS  = 128,
  parameter logic [15:0] SEED   = 16'hACE1,
  localparam int unsigned IDX_W = $clog2(ELEMS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [15:0]             rate,
  input  logic [ELEMS*ELEM_W-1:0] in,
  output logic [ELEMS*ELEM_W-1:0] out,
  output logic                    busy,
  output logic                    done,
  output logic                    step_valid,
  output logic [IDX_W-1:0]        step_idx
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_next;
  logic [15:0]      presc_q;
  logic [IDX_W-1:0] idx;
  logic             last_step;

  always_comb begin
    lfsr_next = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_next = lfsr_next ^ 16'hB400;
    end
  end

  assign idx = lfsr_q[15 -: IDX_W];

`ifdef VEC_MORPH_COVER_EN
  logic [ELEMS-1:0] mask_q;
  logic [ELEMS-1:0] mask_next;

  always_comb begin
    mask_next      = mask_q;
    mask_next[idx] = 1'b1;
  end

  // Final step is the one that completes coverage of every index.
  assign last_step = &mask_next;
`else
  localparam int unsigned StepsEff = (STEPS == 0) ? 1 : STEPS;
  localparam int unsigned CntW     = (StepsEff > 1) ? $clog2(StepsEff) : 1;

  // Counts steps already taken in this run; the step taken while it holds
  // StepsEff-1 is the last one.
  logic [CntW-1:0] cnt_q;

  assign last_step = (cnt_q == CntW'(StepsEff - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lfsr_q     <= SEED;
      presc_q    <= '0;
      out        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_valid <= 1'b0;
      step_idx   <= '0;
`ifdef VEC_MORPH_COVER_EN
      mask_q     <= '0;
`else
      cnt_q      <= '0;
`endif
    end else begin
      lfsr_q     <= lfsr_next;
      done       <= 1'b0;
      step_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_q <= StRun;
            busy    <= 1'b1;
            presc_q <= rate;
`ifdef VEC_MORPH_COVER_EN
            mask_q  <= '0;
`else
            cnt_q   <= '0;
`endif
          end
        end
        StRun: begin
          if (abort) begin
            // Abort wins over a step due in the same cycle.
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (presc_q == 16'd0) begin
            out[idx*ELEM_W +: ELEM_W] <= in[idx*ELEM_W +: ELEM_W];
            presc_q    <= rate;
            step_valid <= 1'b1;
            step_idx   <= idx;
`ifdef VEC_MORPH_COVER_EN
            mask_q     <= mask_next;
`else
            cnt_q      <= cnt_q + 1'b1;
`endif
            if (last_step) begin
              done    <= 1'b1;
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            presc_q <= presc_q - 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vec_morph.md
VEC_MORPH -- requirements
Module: vec_morph

Interface
REQ-001 Parameter ELEMS, default 32, number of vector elements; power of two, 2..256.
REQ-002 Parameter ELEM_W, default 8, bits per element.
REQ-003 Parameter STEPS, default 128, step count per run when coverage tracking is compiled out.
REQ-004 Parameter SEED, default 16'hACE1, LFSR reset value; must be nonzero.
REQ-005 Localparam IDX_W = log2(ELEMS).
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 Reset is asynchronous and active-low: rst_n  input  1  clears all state immediately when low.
REQ-008 start  input  1  one-cycle pulse; begins a morph run.
REQ-009 abort  input  1  one-cycle pulse; ends a run without completion.
REQ-010 rate  input  16  step interval; steps occur every rate+1 cycles.
REQ-011 in  input  ELEMS*ELEM_W  target vector; element k occupies bits [k*ELEM_W +: ELEM_W].
REQ-012 out  output  ELEMS*ELEM_W  morphed vector, registered.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 step_valid  output  1  one-cycle pulse in each cycle where a step is taken.
REQ-016 step_idx  output  IDX_W  element index copied in that step; valid only with step_valid.

Function
REQ-017 16-bit Galois LFSR, mask 16'hB400, shifts every clock while rst_n is high, in all states.
REQ-018 Random index = LFSR[15 -: IDX_W].
REQ-019 FSM states IDLE and RUN only; reset enters IDLE.
REQ-020 IDLE: out holds; start=1 and abort=0 -> RUN, prescaler <= rate, step counter <= 0, coverage mask <= 0.
REQ-021 IDLE: start and abort asserted together -> remain IDLE.
REQ-022 RUN: prescaler==0 -> step taken; otherwise prescaler decrements.
REQ-023 A step copies element in[idx] to out[idx], reloads prescaler with rate, and pulses step_valid with step_idx=idx; all other out elements hold.
REQ-024 rate=0 gives one step every RUN cycle; first step occurs in the first RUN cycle.
REQ-025 rate is sampled at start and at each reload; changes mid-interval take effect only at the next reload.
REQ-026 Repeated selection of the same index is legal; the element is re-copied from the current in.
REQ-027 Completion step: done pulses in the same cycle as the final step_valid; FSM returns to IDLE; busy low the following cycle.
REQ-028 abort in RUN -> IDLE next cycle; no done; no step in the abort cycle; out retains partial state.
REQ-029 start while in RUN is ignored.

Reset
REQ-030 rst_n low clears the following: out=0, busy=0, done=0, step_valid=0, step_idx=0, prescaler=0, step counter=0, mask=0, FSM=IDLE, LFSR=SEED.
REQ-031 Reset asserted mid-run aborts with no done pulse; the run does not resume after release.

Configuration
REQ-032 Macro VEC_MORPH_COVER_EN defined: ELEMS-bit mask tracks copied indices; the run completes on the step that makes the mask all-ones; STEPS is ignored.
REQ-033 VEC_MORPH_COVER_EN undefined: no mask logic; the run completes on the STEPS-th step; STEPS=0 is treated as 1.

Verification (ELEMS=8, ELEM_W=8 unless noted)
REQ-034 Hold rst_n low -> out=0, busy=0, done=0, step_valid=0; after release, LFSR sequence begins at 16'hACE1.
REQ-035 COVER_EN, in=all 8'hFF, rate=0, start -> out reaches all 8'hFF, exactly one done pulse coincident with the last step_valid, the 8 distinct step_idx values all seen, busy low next cycle.
REQ-036 rate=3 -> step_valid pulses spaced exactly 4 cycles apart; first pulse 4 cycles after start plus one.
REQ-037 Abort after 3 steps -> busy low next cycle, no done, exactly the stepped elements hold in values, and all others hold 0.
REQ-038 COVER_EN undefined, STEPS=20, rate=1 -> exactly 20 step_valid pulses 2 cycles apart, done with the 20th; start pulse during the run has no effect.
REQ-039 start+abort together in IDLE -> stays IDLE; rst_n low mid-run -> out=0 immediately, no done.
